msk_mcinv_col_feeder: RTL and testbench

MSK_MCINV_COL_FEEDER -- requirements
Module: msk_mcinv_col_feeder

---
 rtl/msk_mcinv_col_feeder.sv | 117 +++++++++++
 tb/tb_msk_mcinv_col_feeder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/msk_mcinv_col_feeder.sv
// Masked 4x4 column buffer feeding inverse MixColumns: fill four columns, then drain them in order.
// Build option FEEDER_INV_SHIFTROWS_EN folds inverse ShiftRows into the output byte routing.

module msk_mcinv_row_sel #(
    parameter int BW = 16
) (
    input  logic [3:0][BW-1:0] row_bytes,
    input  logic [1:0]         sel,
    input  logic               en,
    output logic [BW-1:0]      q
);
    // Whole-field select only; shares are routed together and never combined.
    assign q = en ? row_bytes[sel] : '0;
endmodule

module msk_mcinv_col_feeder #(
    parameter int d = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8*d-1:0]   in_b0,
    input  logic [8*d-1:0]   in_b1,
    input  logic [8*d-1:0]   in_b2,
    input  logic [8*d-1:0]   in_b3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8*d-1:0]   out_b0,
    output logic [8*d-1:0]   out_b1,
    output logic [8*d-1:0]   out_b2,
    output logic [8*d-1:0]   out_b3,
    output logic [1:0]       out_idx,
    output logic             out_last
);
    localparam int BW = 8*d;

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                     state;
    logic [1:0]                 cnt;
    logic [3:0][3:0][BW-1:0]    buf_q;     // [row][col]
    logic [3:0][BW-1:0]         in_col;
    logic [3:0][BW-1:0]         out_col;

    assign in_col = {in_b3, in_b2, in_b1, in_b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= 2'd0;
            buf_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_idx   <= 2'd0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        for (int r = 0; r < 4; r++)
                            buf_q[r][cnt] <= in_col[r];
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_idx   <= 2'd0;
                            out_last  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state     <= FILL;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_idx   <= 2'd0;
                            out_last  <= 1'b0;
                        end else begin
                            out_idx  <= cnt + 2'd1;
                            out_last <= (cnt == 2'd2);
                        end
                    end
                end
                default: begin
                    state <= FILL;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    // Output bytes are a register-driven mux; zeroed whenever no column is presented.
    for (genvar r = 0; r < 4; r++) begin : g_row
        logic [1:0] sel;
`ifdef FEEDER_INV_SHIFTROWS_EN
        assign sel = cnt - 2'(r);
`else
        assign sel = cnt;
`endif
        msk_mcinv_row_sel #(.BW(BW)) u_sel (
            .row_bytes (buf_q[r]),
            .sel       (sel),
            .en        (out_valid),
            .q         (out_col[r])
        );
    end

    assign out_b0 = out_col[0];
    assign out_b1 = out_col[1];
    assign out_b2 = out_col[2];
    assign out_b3 = out_col[3];

endmodule

// File: tb/tb_msk_mcinv_col_feeder.sv
// Directed bench for msk_mcinv_col_feeder: table of expected drained columns plus corner-case sequences.
// Expected routing follows FEEDER_INV_SHIFTROWS_EN when the bench is built with it.

module tb_msk_mcinv_col_feeder;
    localparam int D  = 2;
    localparam int BW = 8*D;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_b0 = '0, in_b1 = '0, in_b2 = '0, in_b3 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_b0, out_b1, out_b2, out_b3;
    logic [1:0]    out_idx;
    logic          out_last;

    always #5 clk = ~clk;

    msk_mcinv_col_feeder #(.d(D)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_b0(in_b0), .in_b1(in_b1), .in_b2(in_b2), .in_b3(in_b3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_b0(out_b0), .out_b1(out_b1), .out_b2(out_b2), .out_b3(out_b3),
        .out_idx(out_idx), .out_last(out_last)
    );

    typedef struct {
        logic [1:0]          idx;
        logic                last;
        logic [3:0][BW-1:0]  b;
    } exp_t;

    exp_t tbl[4];
    int   npass = 0;
    int   ntot  = 0;

    // Share 0 carries the byte 16*c+r, share 1 its complement, so both shares are checked.
    function automatic logic [BW-1:0] fld(int c, int r);
        logic [7:0] v;
        v = 8'(16*c + r);
        return {~v, v};
    endfunction

    function automatic int src_col(int j, int i);
`ifdef FEEDER_INV_SHIFTROWS_EN
        return (j - i + 4) % 4;
`else
        return j;
`endif
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_col(bit v, int c, bit junk);
        in_valid = v;
        in_b0 = junk ? 16'hDEA0 : fld(c, 0);
        in_b1 = junk ? 16'hDEA1 : fld(c, 1);
        in_b2 = junk ? 16'hDEA2 : fld(c, 2);
        in_b3 = junk ? 16'hDEA3 : fld(c, 3);
    endtask

    task automatic chk_out(string tag, int j);
        chk($sformatf("%s_valid%0d", tag, j), 32'(out_valid), 32'd1);
        chk($sformatf("%s_idx%0d", tag, j), 32'(out_idx), 32'(tbl[j].idx));
        chk($sformatf("%s_last%0d", tag, j), 32'(out_last), 32'(tbl[j].last));
        chk($sformatf("%s_inrdy%0d", tag, j), 32'(in_ready), 32'd0);
        chk($sformatf("%s_b0_%0d", tag, j), 32'(out_b0), 32'(tbl[j].b[0]));
        chk($sformatf("%s_b1_%0d", tag, j), 32'(out_b1), 32'(tbl[j].b[1]));
        chk($sformatf("%s_b2_%0d", tag, j), 32'(out_b2), 32'(tbl[j].b[2]));
        chk($sformatf("%s_b3_%0d", tag, j), 32'(out_b3), 32'(tbl[j].b[3]));
    endtask

    task automatic fill_std(string tag);
        for (int c = 0; c < 4; c++) begin
            drive_col(1'b1, c, 1'b0);
            chk($sformatf("%s_fill_rdy%0d", tag, c), 32'(in_ready), 32'd1);
            chk($sformatf("%s_fill_ov%0d", tag, c), 32'(out_valid), 32'd0);
            step();
        end
        drive_col(1'b0, 0, 1'b1);
    endtask

    task automatic drain_from(string tag, int j0);
        out_ready = 1'b1;
        for (int j = j0; j < 4; j++) begin
            chk_out(tag, j);
            step();
        end
        chk({tag, "_back_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_back_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_back_last"}, 32'(out_last), 32'd0);
    endtask

    task automatic chk_idle(string tag);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_idx"}, 32'(out_idx), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
        chk({tag, "_b"}, {out_b1, out_b0}, 32'd0);
        chk({tag, "_b23"}, {out_b3, out_b2}, 32'd0);
    endtask

    initial begin
        for (int j = 0; j < 4; j++) begin
            tbl[j].idx  = 2'(j);
            tbl[j].last = (j == 3);
            for (int i = 0; i < 4; i++)
                tbl[j].b[i] = fld(src_col(j, i), i);
        end

        // Reset held for two edges
        rst = 1'b1;
        step();
        step();
        chk_idle("rst");
        rst = 1'b0;

        // Basic transfer with out_ready held high
        out_ready = 1'b1;
        fill_std("basic");
        drain_from("basic", 0);

        // Backpressure at idx 2 with in_valid pulses that must be ignored
        fill_std("bp");
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_col(k % 2 == 0, 0, 1'b1);
            chk_out($sformatf("bp_hold%0d", k), 2);
            step();
        end
        drive_col(1'b0, 0, 1'b1);
        drain_from("bp_resume", 2);

        // Reset in the middle of draining
        fill_std("rdr");
        out_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        chk_idle("rst_drain");
        rst = 1'b0;

        // Reset after two accepted junk columns; only new columns may come out
        out_ready = 1'b1;
        drive_col(1'b1, 0, 1'b1);
        step();
        step();
        drive_col(1'b0, 0, 1'b1);
        rst = 1'b1;
        step();
        chk_idle("rst_fill");
        rst = 1'b0;
        fill_std("after_rst");
        drain_from("after_rst", 0);

        // Gapped input: in_valid 1,0,1,0... with downstream stalled
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive_col(k % 2 == 0, k / 2, 1'b0);
            chk($sformatf("gap_rdy%0d", k), 32'(in_ready), (k < 7) ? 32'd1 : 32'd0);
            step();
        end
        drive_col(1'b0, 0, 1'b1);
        drain_from("gap", 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
